// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Definitions shared by the instruction memory fetch block:
//   IMEM_NOP           - instruction returned on a faulted fetch (all zeros)
//   IMEM_DEFAULT_BASE  - default PC that maps to word 0 (index = pc/4 - 1)
//   imem_state_t       - response FSM states (EMPTY, FULL, LOAD)
//   imem_word_index()  - word index of a byte PC relative to the base address
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] IMEM_NOP          = 32'h0000_0000;
    localparam logic [31:0] IMEM_DEFAULT_BASE = 32'h0000_0004;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    // Operands are zero-extended by the caller to 64 bits so one function
    // serves any PC width up to 64. A PC below the base wraps to a huge
    // index, but that case is flagged as a fault separately.
    function automatic logic [63:0] imem_word_index(input logic [63:0] pc,
                                                    input logic [63:0] base);
        return (pc - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x DATA_W instruction RAM: synchronous write, registered read.
// Contents start all-zero at elaboration and are filled through the write
// port; INIT_FILE is accepted for interface compatibility.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write word index
//   wr_data  in   write data
//   rd_en    in   read enable; rd_data updates only when high
//   rd_addr  in   read word index
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module imem_array #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter     INIT_FILE = "",
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Elaboration-time image; contents are never touched by reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // Index checks only matter for non-power-of-two DEPTH, where the
    // address width can express words that do not exist.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en && (int'(rd_addr) < DEPTH)) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
// Instruction memory with a valid/ready fetch handshake, programmable base
// address, out-of-range fault reporting and a boot-loader write port.
// Optional build macro: IMEM_ALIGN_CHK_EN - when defined, a PC with nonzero
// low two bits faults; otherwise the low bits are ignored.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    fetch request handshake, req_pc = byte PC
//   rsp_valid/rsp_ready    response handshake
//   rsp_instr/rsp_pc       fetched instruction (NOP on fault) and its PC
//   rsp_fault              out-of-range (or misaligned) request
//   flush                  discard held response and this cycle's request
//   ld_en/ld_addr/ld_data  loader write port (one word per cycle)
// -----------------------------------------------------------------------------
module imem_fetch
    import imem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(IMEM_DEFAULT_BASE),
    parameter                    INIT_FILE = "",
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    imem_state_t       r_state;
    imem_state_t       w_state_next;
    logic              r_held;
    logic              w_held_next;
    logic              w_capture;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fault;

    logic [63:0]       w_pc_ext;
    logic [63:0]       w_base_ext;
    logic [63:0]       w_idx_full;
    logic              w_below;
    logic              w_out_of_range;
    logic              w_misalign;
    logic              w_fault;
    logic              w_accept;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;

    // ---------------- range check ----------------
    always_comb begin
        w_pc_ext                = '0;
        w_pc_ext[ADDR_W-1:0]    = req_pc;
        w_base_ext              = '0;
        w_base_ext[ADDR_W-1:0]  = BASE_ADDR;
    end

    assign w_idx_full     = imem_word_index(w_pc_ext, w_base_ext);
    assign w_below        = (req_pc < BASE_ADDR);
    assign w_out_of_range = (w_idx_full >= 64'(DEPTH));

`ifdef IMEM_ALIGN_CHK_EN
    assign w_misalign = (req_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_below | w_out_of_range | w_misalign;

    // ---------------- handshake ----------------
    // A held response is frozen while loading, so only LOAD needs r_held.
    assign rsp_valid = (r_state == FULL) || ((r_state == LOAD) && r_held);
    assign req_ready = !ld_en && (!rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;
    // Faulted requests never touch the array.
    assign w_rd_en   = w_accept && !w_fault;

    // ---------------- FSM ----------------
    always_comb begin
        w_held_next  = rsp_valid;
        w_capture    = 1'b0;
        w_state_next = r_state;
        if (flush) begin
            w_held_next = 1'b0;
        end else if (ld_en) begin
            w_held_next = rsp_valid;
        end else if (w_accept) begin
            w_held_next = 1'b1;
            w_capture   = 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            w_held_next = 1'b0;
        end

        if (ld_en) begin
            w_state_next = LOAD;
        end else if (w_held_next) begin
            w_state_next = FULL;
        end else begin
            w_state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_held  <= 1'b0;
            r_pc    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_held  <= w_held_next;
            if (w_capture) begin
                r_pc    <= req_pc;
                r_fault <= w_fault;
            end
        end
    end

    // ---------------- storage ----------------
    imem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_idx_full[AW-1:0]),
        .rd_data (w_rd_data)
    );

    // The read register has no reset, so the instruction is masked to NOP
    // whenever no valid, non-faulted response is held.
    assign rsp_instr = (rsp_valid && !r_fault) ? w_rd_data : DATA_W'(IMEM_NOP);
    assign rsp_pc    = r_pc;
    assign rsp_fault = r_fault;

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_fault;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always #5 clk = ~clk;

    imem_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: memory image plus the single held response.
    logic [31:0] m_mem [32];
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    bit          m_fault = 1'b0;

    localparam logic [31:0] W0  = 32'ha2310011;
    localparam logic [31:0] W1  = 32'ha2520003;
    localparam logic [31:0] W31 = 32'h1234abcd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_fault(input logic [31:0] pc);
        logic [31:0] off;
        if (pc < 32'd4) return 1'b1;
        off = (pc - 32'd4) >> 2;
        if (off >= 32'd32) return 1'b1;
`ifdef IMEM_ALIGN_CHK_EN
        if (pc[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - 32'd4) >> 2;
        return m_mem[off[4:0]];
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl,
                         input bit ld, input logic [4:0] a, input logic [31:0] d);
        req_valid = v;
        req_pc    = pc;
        rsp_ready = rdy;
        flush     = fl;
        ld_en     = ld;
        ld_addr   = a;
        ld_data   = d;
    endtask

    // One clock cycle: compare DUT to model mid-cycle, then advance the model.
    task automatic tick;
        bit          exp_ready;
        bit          accept;
        bit          n_valid;
        logic [31:0] n_instr;
        logic [31:0] n_pc;
        bit          n_fault;
        @(negedge clk);
        exp_ready = !ld_en && (!m_valid || rsp_ready);
        check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
        check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("rsp_instr", {32'd0, rsp_instr}, {32'd0, m_instr});
            check("rsp_pc",    {32'd0, rsp_pc},    {32'd0, m_pc});
            check("rsp_fault", {63'd0, rsp_fault}, {63'd0, m_fault});
            if (rsp_ready && !ld_en && !flush)
                $display("xact pc=%h instr=%h fault=%0d", m_pc, m_instr, m_fault);
        end
        accept  = req_valid && exp_ready;
        n_valid = m_valid;
        n_instr = m_instr;
        n_pc    = m_pc;
        n_fault = m_fault;
        if (flush) begin
            n_valid = 1'b0;
        end else if (ld_en) begin
            n_valid = m_valid;
        end else if (accept) begin
            n_valid = 1'b1;
            n_pc    = req_pc;
            n_fault = exp_fault(req_pc);
            n_instr = n_fault ? 32'd0 : exp_word(req_pc);
        end else if (m_valid && rsp_ready) begin
            n_valid = 1'b0;
        end
        if (ld_en) m_mem[ld_addr] = ld_data;
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_instr = n_instr;
        m_pc    = n_pc;
        m_fault = n_fault;
    endtask

    initial begin
        logic [31:0] wd;
        logic [31:0] pc;
        // ---------------- reset with a request pending ----------------
        drive(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset rsp_instr", {32'd0, rsp_instr}, 64'd0);
        check("reset rsp_pc",    {32'd0, rsp_pc},    64'd0);
        check("reset rsp_fault", {63'd0, rsp_fault}, 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;

        // ---------------- fill the array through the loader ----------------
        for (int i = 0; i < 32; i++) begin
            wd = (i == 0) ? W0 : (i == 1) ? W1 : (i == 31) ? W31 : $urandom;
            drive(1'b1, 32'd4, ($urandom_range(0, 1) == 1), 1'b0, 1'b1, 5'(i), wd);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();

        // ---------------- streaming ----------------
        drive(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("stream0 instr", {32'd0, rsp_instr}, {32'd0, W0});
        check("stream0 pc",    {32'd0, rsp_pc},    64'd4);
        drive(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("stream1 instr", {32'd0, rsp_instr}, {32'd0, W1});
        check("stream1 pc",    {32'd0, rsp_pc},    64'd8);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();

        // ---------------- backpressure ----------------
        drive(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            #1;
            check("bp req_ready", {63'd0, req_ready}, 64'd0);
            tick();
            check("bp hold instr", {32'd0, rsp_instr}, {32'd0, W0});
            check("bp hold pc",    {32'd0, rsp_pc},    64'd4);
        end
        drive(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        check("bp release ready", {63'd0, req_ready}, 64'd1);
        tick();
        check("bp next instr", {32'd0, rsp_instr}, {32'd0, W1});

        // ---------------- range ----------------
        drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("pc0 fault", {63'd0, rsp_fault}, 64'd1);
        check("pc0 instr", {32'd0, rsp_instr}, 64'd0);
        drive(1'b1, 32'd132, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("pc132 fault", {63'd0, rsp_fault}, 64'd1);
        check("pc132 instr", {32'd0, rsp_instr}, 64'd0);
        drive(1'b1, 32'd128, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("pc128 fault", {63'd0, rsp_fault}, 64'd0);
        check("pc128 instr", {32'd0, rsp_instr}, {32'd0, W31});

        // ---------------- loader then fetch ----------------
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hdeadbeef);
        tick();
        drive(1'b1, 32'd24, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("ld word5", {32'd0, rsp_instr}, 64'hdeadbeef);

        // ---------------- flush on accept ----------------
        drive(1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        check("flush rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // ---------------- alignment ----------------
        drive(1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
`ifdef IMEM_ALIGN_CHK_EN
        check("pc6 fault", {63'd0, rsp_fault}, 64'd1);
        check("pc6 instr", {32'd0, rsp_instr}, 64'd0);
`else
        check("pc6 fault", {63'd0, rsp_fault}, 64'd0);
        check("pc6 instr", {32'd0, rsp_instr}, {32'd0, W0});
`endif

        // ---------------- reset mid-response ----------------
        drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("pre-reset valid", {63'd0, rsp_valid}, 64'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset valid", {63'd0, rsp_valid}, 64'd0);
        check("async reset pc",    {32'd0, rsp_pc},    64'd0);
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 2000; c++) begin
            case ($urandom_range(0, 3))
                0: pc = 32'd4 + 32'd4 * $urandom_range(0, 35);
                1: pc = $urandom_range(0, 200);
                2: pc = 32'd4 * $urandom_range(0, 40);
                default: pc = $urandom;
            endcase
            drive(($urandom_range(0, 9) < 7), pc, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                  5'($urandom_range(0, 31)), $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
